param_mux_scanner: RTL and testbench
====================================

PARAM_MUX_SCANNER -- requirements
Module: param_mux_scanner

Interface
REQ-001 Parameter WIDTH, default 2: bit width of each channel and of data_out.
REQ-002 Parameter CHANNELS, default 4: number of input channels; power of two, 2..16.
REQ-003 Parameter DWELL, default 4: cycles spent on each channel in scan mode; range 1..255.
REQ-004 Derived constant SEL_W = clog2(CHANNELS), default 2.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 data_in  input  CHANNELS*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  input  SEL_W  manual channel select.
REQ-009 mode  input  1  0 = manual, 1 = scan.
REQ-010 hold  input  1  freezes scan progress while high.
REQ-011 data_out  output  WIDTH  registered copy of the selected channel.
REQ-012 cur_sel  output  SEL_W  channel currently selected.
REQ-013 valid  output  1  data_out holds post-reset channel data.
REQ-014 wrap  output  1  one-cycle pulse when the scan wraps from CHANNELS-1 to 0.

Function
REQ-015 data_out SHALL equal data_in[cur_sel] sampled at the previous edge; latency is one cycle, independent of mode and hold.
REQ-016 In manual mode, cur_sel SHALL load sel on every edge; the dwell counter SHALL hold 0; wrap SHALL stay 0.
REQ-017 In scan mode, the dwell counter SHALL count 0..DWELL-1; on the edge where it equals DWELL-1, it SHALL return to 0 and cur_sel SHALL advance by 1.
REQ-018 Advance from CHANNELS-1 SHALL wrap cur_sel to 0; wrap SHALL be 1 for exactly the following cycle.
REQ-019 With DWELL=1, cur_sel SHALL advance on every scan-mode edge.
REQ-020 hold=1 in scan mode SHALL freeze the dwell counter and cur_sel; data_out SHALL keep tracking data_in[cur_sel]; wrap SHALL be 0.
REQ-021 hold SHALL have no effect in manual mode.
REQ-022 Manual to scan: scanning SHALL start from the current cur_sel with dwell counter 0.
REQ-023 Scan to manual: on the first manual edge, cur_sel SHALL load sel and the dwell counter SHALL clear, even mid-dwell.
REQ-024 valid SHALL be 0 during reset and SHALL become 1 on the first edge after reset deasserts, then stay 1.

Reset
REQ-025 While reset=1 at an edge: data_out=0, cur_sel=0, dwell counter=0, valid=0, wrap=0.
REQ-026 Reset SHALL override mode, hold and sel, including in the middle of a dwell or on a wrap edge.
REQ-027 The first edge after reset SHALL behave as a normal edge from the reset state.

Structure
REQ-028 The shared package mux_pkg SHALL hold the clog2 function and the MODE_MANUAL and MODE_SCAN encodings.
REQ-029 The dwell counter SHALL be a sub-module named dwell_counter.
  - Parameter: DWELL.
  - Ports: clk, reset, enable, clear, terminal.
REQ-030 The channel mux SHALL be combinational indexed slicing feeding the data_out register; the top level has no latches.

Verification (WIDTH=2, CHANNELS=4, DWELL=3 unless stated)
REQ-031 Manual mode; data_in channels {3,2,1,0} = {2'b11,2'b10,2'b01,2'b00}; sel steps 0,1,2,3 -> data_out 00,01,10,11, each one cycle after sel.
REQ-032 Scan mode from reset, same data -> cur_sel 0,0,0,1,1,1,2,2,2,3,3,3,0; wrap high only the cycle after 3->0.
REQ-033 Scan; hold=1 for 5 cycles at cur_sel=2, dwell count=1 -> cur_sel stays 2; after release, 2 more cycles on channel 2, then 3.
REQ-034 Scan at cur_sel=1, dwell count=2; switch to manual with sel=3 -> next edge cur_sel=3; return to scan -> 3 cycles on channel 3, then 0 with wrap pulse.
REQ-035 Assert reset for one edge while cur_sel=3, dwell count=2 (a wrap edge) -> data_out=0, cur_sel=0, valid=0, no wrap pulse; valid=1 one edge after release.
REQ-036 Re-run with CHANNELS=8, WIDTH=5, DWELL=1 -> cur_sel advances every edge 0..7, wraps, and wrap pulses every 8 cycles.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg
// Shared definitions for the channel scanner:
//   MODE_MANUAL / MODE_SCAN : encodings of the 'mode' input
//   clog2()                 : ceiling log2 used to size the channel select
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Ceiling log2 for elaboration-time sizing. Bounded loop so it stays
  // usable as a constant function in every tool.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// dwell_counter
// Counts 0..DWELL-1 while enabled and wraps back to 0.
// Ports:
//   clk      : clock, all updates on rising edge
//   reset    : synchronous active-high reset, count -> 0
//   enable   : advance the count this edge
//   clear    : force count to 0 this edge (takes priority over enable)
//   terminal : high when enabled and the count sits at DWELL-1, i.e. this
//              edge ends the dwell
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic terminal
);

  // DWELL is at most 255, so 8 bits always suffice.
  localparam logic [7:0] LAST = 8'(DWELL - 1);

  logic [7:0] count_reg;

  assign terminal = enable && (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= 8'd0;
    end else if (enable) begin
      if (count_reg == LAST) begin
        count_reg <= 8'd0;
      end else begin
        count_reg <= count_reg + 8'd1;
      end
    end
  end

endmodule

// File: rtl/param_mux_scanner.sv
// param_mux_scanner
// Channel selector that either follows a manual select or scans through all
// channels, dwelling DWELL cycles on each one.
// Ports:
//   clk      : clock
//   reset    : synchronous active-high reset
//   data_in  : CHANNELS*WIDTH flattened channels, channel k at [k*WIDTH +: WIDTH]
//   sel      : manual channel select
//   mode     : MODE_MANUAL (0) or MODE_SCAN (1)
//   hold     : freezes scan progress while high (ignored in manual mode)
//   data_out : registered copy of data_in[cur_sel]
//   cur_sel  : channel currently selected
//   valid    : data_out holds post-reset data
//   wrap     : one-cycle pulse after the scan wraps CHANNELS-1 -> 0
module param_mux_scanner
  import mux_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  localparam int SEL_W   = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      valid,
  output logic                      wrap
);

  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0] chan [CHANNELS];
  logic [WIDTH-1:0] selected;
  logic             scan_mode;
  logic             scan_step;
  logic             dwell_done;

  logic [WIDTH-1:0] data_out_reg;
  logic [SEL_W-1:0] cur_sel_reg;
  logic             valid_reg;
  logic             wrap_reg;

  // Unflatten the channel bus so the mux is a plain array index.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign chan[gi] = data_in[gi*WIDTH +: WIDTH];
  end

  assign selected  = chan[cur_sel_reg];
  assign scan_mode = (mode == MODE_SCAN);
  assign scan_step = scan_mode && !hold;

  // Manual mode keeps the counter cleared so a later switch to scan starts
  // a fresh dwell on whatever channel manual mode left selected.
  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .enable   (scan_step),
    .clear    (!scan_mode),
    .terminal (dwell_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_reg <= '0;
      cur_sel_reg  <= '0;
      valid_reg    <= 1'b0;
      wrap_reg     <= 1'b0;
    end else begin
      data_out_reg <= selected;
      valid_reg    <= 1'b1;
      wrap_reg     <= 1'b0;
      if (!scan_mode) begin
        cur_sel_reg <= sel;
      end else if (dwell_done) begin
        // CHANNELS is a power of two, so the increment wraps naturally.
        cur_sel_reg <= cur_sel_reg + SEL_ONE;
        wrap_reg    <= (cur_sel_reg == SEL_LAST);
      end
    end
  end

  assign data_out = data_out_reg;
  assign cur_sel  = cur_sel_reg;
  assign valid    = valid_reg;
  assign wrap     = wrap_reg;

endmodule

// File: tb/tb_param_mux_scanner.sv
// Self-checking bench for param_mux_scanner.
// Instance a: WIDTH=2, CHANNELS=4, DWELL=3, channel k carries value k.
// Instance b: WIDTH=5, CHANNELS=8, DWELL=1, permanently in scan mode,
//             channel k carries value 16+k.
module tb_param_mux_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] data_in;
  logic [1:0] sel;
  logic       mode;
  logic       hold;
  logic [1:0] data_out;
  logic [1:0] cur_sel;
  logic       valid;
  logic       wrap;

  logic [39:0] data_in_b;
  logic [2:0]  sel_b;
  logic        mode_b;
  logic        hold_b;
  logic [4:0]  data_out_b;
  logic [2:0]  cur_sel_b;
  logic        valid_b;
  logic        wrap_b;

  int n_cmp = 0;
  int n_bad = 0;

  param_mux_scanner #(.WIDTH(2), .CHANNELS(4), .DWELL(3)) dut_a (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .sel      (sel),
    .mode     (mode),
    .hold     (hold),
    .data_out (data_out),
    .cur_sel  (cur_sel),
    .valid    (valid),
    .wrap     (wrap)
  );

  param_mux_scanner #(.WIDTH(5), .CHANNELS(8), .DWELL(1)) dut_b (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in_b),
    .sel      (sel_b),
    .mode     (mode_b),
    .hold     (hold_b),
    .data_out (data_out_b),
    .cur_sel  (cur_sel_b),
    .valid    (valid_b),
    .wrap     (wrap_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one edge and settle away from it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m);
    mode  = m;
    hold  = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_a(input string tag, input int e_sel, input int e_dout,
                         input int e_valid, input int e_wrap);
    check({tag, " cur_sel"},  32'(cur_sel),  32'(e_sel));
    check({tag, " data_out"}, 32'(data_out), 32'(e_dout));
    check({tag, " valid"},    32'(valid),    32'(e_valid));
    check({tag, " wrap"},     32'(wrap),     32'(e_wrap));
  endtask

  // Hand-derived cur_sel after each scan edge from reset, DWELL=3.
  int scan_sel [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int man_sel  [5]  = '{0, 1, 2, 3, 3};
  int man_dout [5]  = '{0, 0, 1, 2, 3};

  initial begin
    reset     = 1'b1;
    data_in   = 8'b11_10_01_00;
    sel       = 2'd0;
    mode      = 1'b0;
    hold      = 1'b0;
    sel_b     = 3'd5;
    mode_b    = 1'b1;
    hold_b    = 1'b0;
    for (int k = 0; k < 8; k++) data_in_b[k*5 +: 5] = 5'(16 + k);

    // Reset state (sel/mode ignored during reset).
    sel = 2'd2;
    do_reset(1'b1);
    check_a("reset", 0, 0, 0, 0);

    // Manual mode: data_out trails cur_sel by one edge.
    mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sel = 2'(man_sel[i]);
      step();
      check_a($sformatf("manual[%0d]", i), man_sel[i], man_dout[i], 1, 0);
    end

    // hold has no effect in manual mode.
    hold = 1'b1;
    sel  = 2'd2;
    step();
    check("manual hold cur_sel", 32'(cur_sel), 32'd2);
    hold = 1'b0;

    // Scan from reset through one full wrap.
    do_reset(1'b1);
    for (int i = 0; i < 12; i++) begin
      step();
      check_a($sformatf("scan[%0d]", i), scan_sel[i],
              (i == 0) ? 0 : scan_sel[i-1], 1, (i == 11) ? 1 : 0);
    end
    step();
    check("scan after wrap wrap", 32'(wrap), 32'd0);
    check("scan after wrap cur_sel", 32'(cur_sel), 32'd0);

    // Hold at cur_sel=2, dwell count=1 (7 edges from reset).
    do_reset(1'b1);
    repeat (7) step();
    check("pre-hold cur_sel", 32'(cur_sel), 32'd2);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_a($sformatf("hold[%0d]", i), 2, 2, 1, 0);
    end
    hold = 1'b0;
    step();
    check("release+1 cur_sel", 32'(cur_sel), 32'd2);
    step();
    check("release+2 cur_sel", 32'(cur_sel), 32'd3);

    // Scan at cur_sel=1, count=2 (5 edges), switch to manual mid-dwell.
    do_reset(1'b1);
    repeat (5) step();
    check("pre-manual cur_sel", 32'(cur_sel), 32'd1);
    mode = 1'b0;
    sel  = 2'd3;
    step();
    check("to-manual cur_sel", 32'(cur_sel), 32'd3);
    mode = 1'b1;
    step();
    check_a("rescan[0]", 3, 3, 1, 0);
    step();
    check_a("rescan[1]", 3, 3, 1, 0);
    step();
    check_a("rescan[2]", 0, 3, 1, 1);
    step();
    check_a("rescan[3]", 0, 0, 1, 0);

    // Reset on a wrap edge: cur_sel=3, count=2 after 11 edges.
    do_reset(1'b1);
    repeat (11) step();
    check("pre-reset cur_sel", 32'(cur_sel), 32'd3);
    reset = 1'b1;
    step();
    check_a("wrap-edge reset", 0, 0, 0, 0);
    reset = 1'b0;
    step();
    check_a("post-reset", 0, 0, 1, 0);

    // Instance b: DWELL=1, advances every edge, wraps every 8.
    do_reset(1'b1);
    check("b reset cur_sel", 32'(cur_sel_b), 32'd0);
    check("b reset valid", 32'(valid_b), 32'd0);
    for (int i = 1; i <= 17; i++) begin
      step();
      check($sformatf("b[%0d] cur_sel", i),  32'(cur_sel_b),  32'(i % 8));
      check($sformatf("b[%0d] wrap", i),     32'(wrap_b),     (i % 8 == 0) ? 32'd1 : 32'd0);
      check($sformatf("b[%0d] data_out", i), 32'(data_out_b), 32'(16 + ((i - 1) % 8)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
